// File: rtl/gray_mod_counter_pkg.sv
// Shared definitions for the modulo-MOD Gray-code counter.
//   - MAX_W           : widest code the helper functions handle.
//   - bin2gray()      : reflected binary to Gray conversion.
//   - gray2bin()      : Gray to binary conversion.
//   - gray_offset()   : first binary value used, so that the MOD codes are
//                       the middle slice of the reflected Gray sequence.
//   - params_ok()     : legality check on WIDTH / MOD, used at elaboration.
package gray_mod_counter_pkg;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b = g;
        for (int i = 1; i < MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    // (2**w - m) / 2 : centres the MOD codes so the first and last differ only in the MSB.
    function automatic int gray_offset(input int w, input int m);
        return ((32'sd1 <<< w) - m) / 32'sd2;
    endfunction

    function automatic bit params_ok(input int w, input int m);
        return (w >= 32'sd2) && (w < MAX_W) && (m >= 32'sd2) &&
               ((m % 32'sd2) == 32'sd0) && (m <= (32'sd1 <<< w));
    endfunction

endpackage

// File: rtl/gray_mod_counter_if.sv
// Control and status bundle of the Gray-code counter.
//   master : drives en, up, load, load_idx; observes the counter outputs.
//   slave  : the counter itself.
// Signals:
//   en        count enable
//   up        direction, 1 = increment index
//   load      synchronous load request
//   load_idx  index to load, valid 0..MOD-1
//   gray_out  registered Gray code
//   idx_out   registered sequence index
//   tc        combinational terminal count
//   load_err  registered one-cycle pulse after a rejected load
interface gray_mod_counter_if #(
    parameter int WIDTH = 3
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_idx;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] idx_out;
    logic             tc;
    logic             load_err;

    modport master (
        output en, up, load, load_idx,
        input  gray_out, idx_out, tc, load_err
    );

    modport slave (
        input  en, up, load, load_idx,
        output gray_out, idx_out, tc, load_err
    );
endinterface

// File: rtl/gray_mod_counter_tff_reg.sv
// Bank of T flip-flops holding the Gray code.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, loads RST_VAL
//   t_i    toggle mask, bit i flips q_o[i] on the next edge
//   q_o    register contents
module gray_mod_counter_tff_reg #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] t_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Toggle register: each bit flips when its T input is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_q ^ t_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/gray_mod_counter.sv
// Modulo-MOD cyclic Gray-code counter with enable, direction, checked
// index load and terminal-count flag. The code register is a T flip-flop
// bank; each count step toggles exactly one bit, including at wrap-around.
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    gray_mod_counter_if.slave (en, up, load, load_idx in;
//          gray_out, idx_out, tc, load_err out). bus WIDTH must match WIDTH.
module gray_mod_counter
    import gray_mod_counter_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int MOD   = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    gray_mod_counter_if.slave       bus
);

    if (!params_ok(WIDTH, MOD)) begin : g_param_check
        $error("gray_mod_counter: MOD must be even with 2 <= MOD <= 2**WIDTH and WIDTH >= 2");
    end

    localparam int               OFFSET   = gray_offset(WIDTH, MOD);
    localparam logic [WIDTH:0]   OFFSET_W = (WIDTH+1)'(OFFSET);
    localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] ZERO_IDX = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_IDX  = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(MAX_W'(OFFSET)));

    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;
    logic             load_err_q;
    logic             load_err_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_next_s;
    logic [WIDTH:0]   code_bin_s;
    logic [WIDTH-1:0] tff_t_s;
    logic             in_range_s;

    // Next index and load-error decision, load first, then counting.
    always_comb begin
        idx_d      = idx_q;
        load_err_d = 1'b0;
        // Extra MSB so MOD == 2**WIDTH still compares correctly.
        in_range_s = ({1'b0, bus.load_idx} < MOD_W);
        if (bus.load) begin
            if (in_range_s) begin
                idx_d      = bus.load_idx;
                load_err_d = 1'b0;
            end else begin
                idx_d      = idx_q;
                load_err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                idx_d = (idx_q == LAST_IDX) ? ZERO_IDX : (idx_q + ONE_IDX);
            end else begin
                idx_d = (idx_q == ZERO_IDX) ? LAST_IDX : (idx_q - ONE_IDX);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Gray code of the next index; the sum is kept one bit wider and can
    // never exceed 2**WIDTH-1, so the truncation below loses nothing.
    always_comb begin
        code_bin_s  = {1'b0, idx_d} + OFFSET_W;
        gray_next_s = WIDTH'(bin2gray(MAX_W'(code_bin_s)));
        tff_t_s     = gray_q ^ gray_next_s;
    end

    // Index and load-error registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= ZERO_IDX;
            load_err_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            load_err_q <= load_err_d;
        end
    end

    gray_mod_counter_tff_reg #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_GRAY)
    ) u_code_reg (
        .clk   (clk),
        .rst_n (reset),
        .t_i   (tff_t_s),
        .q_o   (gray_q)
    );

    assign bus.gray_out = gray_q;
    assign bus.idx_out  = idx_q;
    assign bus.load_err = load_err_q;
    // Terminal count: high in the cycle whose step wraps the index.
    assign bus.tc = bus.en & ~bus.load &
                    ((bus.up & (idx_q == LAST_IDX)) | (~bus.up & (idx_q == ZERO_IDX)));

endmodule

// File: tb/tb_gray_mod_counter.sv
module tb_gray_mod_counter;
    import gray_mod_counter_pkg::*;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    gray_mod_counter_if #(.WIDTH(3)) bus_a ();
    gray_mod_counter_if #(.WIDTH(4)) bus_b ();

    gray_mod_counter #(.WIDTH(3), .MOD(6))  dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    gray_mod_counter #(.WIDTH(4), .MOD(10)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic [2:0] load_idx;
        logic       en;
        logic       up;
        logic       exp_tc;
        logic [2:0] exp_gray;
        logic [2:0] exp_idx;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic void add(input logic l, input logic [2:0] li, input logic e,
                                input logic u, input logic tc, input logic [2:0] g,
                                input logic [2:0] i, input logic err);
        vec_t v;
        v.load = l; v.load_idx = li; v.en = e; v.up = u;
        v.exp_tc = tc; v.exp_gray = g; v.exp_idx = i; v.exp_err = err;
        vecs.push_back(v);
    endfunction

    // Codes for WIDTH=4, MOD=10 (binary 3..12 in reflected Gray).
    logic [3:0] tab_b [10];

    initial begin
        logic [2:0] prev_a;
        logic [3:0] prev_b;
        int         p;
        int         nx;

        n_pass  = 0;
        n_total = 0;
        tab_b[0] = 4'b0010; tab_b[1] = 4'b0110; tab_b[2] = 4'b0111; tab_b[3] = 4'b0101;
        tab_b[4] = 4'b0100; tab_b[5] = 4'b1100; tab_b[6] = 4'b1101; tab_b[7] = 4'b1111;
        tab_b[8] = 4'b1110; tab_b[9] = 4'b1010;

        // up count through the wrap
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b010, 3'd2, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b110, 3'd3, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b111, 3'd4, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b101, 3'd5, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'b001, 3'd0, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b011, 3'd1, 1'b0);
        // hold with direction toggling
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'd1, 1'b0);
        // good load, bad load, error pulse clears
        add(1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 3'b110, 3'd3, 1'b0);
        add(1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 3'b110, 3'd3, 1'b1);
        add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 3'b110, 3'd3, 1'b0);
        // down count through the wrap
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b010, 3'd2, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b011, 3'd1, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b001, 3'd0, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 3'b101, 3'd5, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b111, 3'd4, 1'b0);
        add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'b110, 3'd3, 1'b0);
        // direction change, loads that override en/up
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 3'b111, 3'd4, 1'b0);
        add(1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'b001, 3'd0, 1'b0);
        add(1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 3'b101, 3'd5, 1'b0);
        add(1'b1, 3'd6, 1'b1, 1'b1, 1'b0, 3'b101, 3'd5, 1'b1);
        add(1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 3'b001, 3'd0, 1'b0);

        reset = 1'b0;
        bus_a.en = 1'b0; bus_a.up = 1'b1; bus_a.load = 1'b0; bus_a.load_idx = 3'd0;
        bus_b.en = 1'b0; bus_b.up = 1'b1; bus_b.load = 1'b0; bus_b.load_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_rst_gray", 32'(bus_a.gray_out), 32'h1);
        chk("a_rst_idx",  32'(bus_a.idx_out),  32'h0);
        chk("a_rst_err",  32'(bus_a.load_err), 32'h0);
        chk("b_rst_gray", 32'(bus_b.gray_out), 32'h2);
        chk("b_rst_idx",  32'(bus_b.idx_out),  32'h0);
        reset = 1'b1;

        // table-driven vectors on the default configuration
        for (int k = 0; k < vecs.size(); k++) begin
            bus_a.load = vecs[k].load; bus_a.load_idx = vecs[k].load_idx;
            bus_a.en = vecs[k].en; bus_a.up = vecs[k].up;
            #1;
            chk($sformatf("a_tc[%0d]", k), 32'(bus_a.tc), 32'(vecs[k].exp_tc));
            prev_a = bus_a.gray_out;
            @(posedge clk);
            #1;
            chk($sformatf("a_gray[%0d]", k), 32'(bus_a.gray_out), 32'(vecs[k].exp_gray));
            chk($sformatf("a_idx[%0d]", k),  32'(bus_a.idx_out),  32'(vecs[k].exp_idx));
            chk($sformatf("a_err[%0d]", k),  32'(bus_a.load_err), 32'(vecs[k].exp_err));
            if (!vecs[k].load) begin
                chk($sformatf("a_bits[%0d]", k), 32'($countones(bus_a.gray_out ^ prev_a)),
                    vecs[k].en ? 32'd1 : 32'd0);
            end
        end

        // count to idx 4, then reset between edges
        bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("a_pre_rst_idx", 32'(bus_a.idx_out), 32'h4);
        #2;
        reset = 1'b0;
        #1;
        chk("a_async_gray", 32'(bus_a.gray_out), 32'h1);
        chk("a_async_idx",  32'(bus_a.idx_out),  32'h0);
        @(posedge clk);
        #1;
        chk("a_rst_hold_gray", 32'(bus_a.gray_out), 32'h1);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("a_resume_gray", 32'(bus_a.gray_out), 32'h3);
        chk("a_resume_idx",  32'(bus_a.idx_out),  32'h1);
        bus_a.en = 1'b0;

        // WIDTH=4, MOD=10: up 11 steps, then down 11 steps
        chk("b_start_gray", 32'(bus_b.gray_out), 32'h2);
        for (int s = 0; s < 22; s++) begin
            bus_b.en = 1'b1;
            bus_b.up = (s < 11) ? 1'b1 : 1'b0;
            p = int'(bus_b.idx_out);
            if (s < 11) nx = (p == 9) ? 0 : p + 1;
            else        nx = (p == 0) ? 9 : p - 1;
            #1;
            chk($sformatf("b_tc[%0d]", s), 32'(bus_b.tc),
                ((s < 11 && p == 9) || (s >= 11 && p == 0)) ? 32'd1 : 32'd0);
            prev_b = bus_b.gray_out;
            @(posedge clk);
            #1;
            chk($sformatf("b_idx[%0d]", s),  32'(bus_b.idx_out),  32'(nx));
            chk($sformatf("b_gray[%0d]", s), 32'(bus_b.gray_out), 32'(tab_b[nx]));
            chk($sformatf("b_bits[%0d]", s), 32'($countones(bus_b.gray_out ^ prev_b)), 32'd1);
            chk($sformatf("b_g2b[%0d]", s),  gray2bin(32'(bus_b.gray_out)), 32'(nx + 3));
        end
        bus_b.en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/gray_mod_counter.md
Name: gray_mod_counter

Overview:
- Parametrised modulo-MOD cyclic Gray-code counter; successor to the fixed 3-bit mod-6 Gray counter.
- Adds:
  - arbitrary even modulus and width
  - count enable
  - up/down direction
  - synchronous index load with range check
  - terminal-count flag
- Exactly one output bit changes per count step, including at wrap-around, so the code can be sampled safely across clock domains or used to drive a low-glitch decoder.
- The output register is built from T flip-flops, as in the existing counter.

Parameters:
- WIDTH, 3, output code width in bits; must be >= 2.
- MOD, 6, sequence length. Must be even and satisfy 2 <= MOD <= 2**WIDTH; any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment index, 0 = decrement.
- load  input  1  synchronous load request.
- load_idx  input  WIDTH  sequence index to load; valid range 0..MOD-1.
- gray_out  output  WIDTH  registered Gray code.
- idx_out  output  WIDTH  registered sequence index, 0..MOD-1.
- tc  output  1  combinational terminal count.
- load_err  output  1  registered one-cycle pulse: the last load was rejected.

Behaviour:
- Code mapping:
  - OFFSET = (2**WIDTH - MOD)/2.
  - gray_out = bin2gray(idx_out + OFFSET), where bin2gray(b) = b ^ (b >> 1).
  - This picks the middle MOD codes of the reflected Gray sequence. The first and last codes differ only in the MSB, so wrap-around is single-bit.
- Reset (reset=0, asynchronous, overrides everything):
  - idx_out = 0
  - gray_out = bin2gray(OFFSET)
  - load_err = 0
  - The reset code is 001 for the defaults WIDTH=3, MOD=6.
  - Asserting reset mid-count takes effect immediately, without waiting for a clock edge. Counting resumes on the first rising edge after reset deasserts.
- Per rising edge, in priority order:
  1. load=1 and load_idx < MOD: idx_out <= load_idx; gray_out follows (may change multiple bits); load_err <= 0. en and up are ignored.
  2. load=1 and load_idx >= MOD: state held; load_err <= 1 for exactly one cycle.
  3. load=0, en=1, up=1: idx_out <= (idx_out == MOD-1) ? 0 : idx_out+1.
  4. load=0, en=1, up=0: idx_out <= (idx_out == 0) ? MOD-1 : idx_out-1.
  5. Otherwise: hold state.
  - load_err is 0 in every case except case 2.
- Latency: one clock from input to the new gray_out and idx_out.
- Invariant: in cases 3 and 4, popcount(gray_out ^ previous gray_out) == 1, including both wrap directions. When the state is held, there are no bit changes at all.
- tc = en & ~load & ((up & idx_out == MOD-1) | (~up & idx_out == 0)). tc is high in the cycle before a wrap occurs.
- Direction may change on any cycle; the next step uses the new direction.
- Index arithmetic is done in WIDTH+1 bits internally; the +OFFSET addition never overflows.
- MOD == 2**WIDTH gives OFFSET = 0, i.e. a full-range Gray counter.

Decomposition:
- Package gray_pkg:
  - function bin2gray(WIDTH)
  - function gray2bin(WIDTH), used by the bench checker
  - localparam expressions for OFFSET
  - elaboration-time checks for MOD and WIDTH
- Sub-module gray_tff_reg, parameter WIDTH:
  - A bank of T flip-flops with async active-low reset and a per-bit reset value.
  - T[i] = gray_out[i] ^ gray_next[i].
  - The top level computes gray_next and instantiates gray_tff_reg to hold gray_out.
  - idx_out is an ordinary D register.

Test Plan:
- Defaults, en=1, up=1, 8 cycles after reset → gray_out = 001, 011, 010, 110, 111, 101, 001, 011. tc=1 only while gray_out=101. Single-bit change checked every step.
- Defaults, en=1, up=0 from reset → 001, 101, 111, 110, 010, 011, 001. tc=1 while idx_out=0.
- Defaults: load=1, load_idx=3 → next gray_out=110, idx_out=3. Then load_idx=7 → state held, load_err=1 for one cycle, then 0.
- Defaults, en=0 for 5 cycles mid-count, with up toggling → gray_out and idx_out constant, tc=0.
- Count to idx 4, assert reset between clock edges → gray_out=001 and idx_out=0 immediately. Counting resumes after release.
- WIDTH=4, MOD=10, up, 11 steps → codes start at 0010 and wrap from 1010 to 0010 with one bit change. Exhaustive single-bit check in both directions.
